// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg
//   Shared definitions for the time-of-day counter:
//   - state_t : FSM state encoding, also driven out on mode_out
//   - sel_t   : set_sel field encoding used in SET mode
//   - SEC_MAX / MIN_MAX : top value of the seconds and minutes fields
//   - cnt_width() : counter width needed to hold 0..modulus-1
package timekeeper_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'b00,
        ST_COUNT = 2'b01,
        ST_SET   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SEL_HR   = 2'b00,
        SEL_MIN  = 2'b01,
        SEL_SEC  = 2'b10,
        SEL_NONE = 2'b11
    } sel_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // Bits needed to hold 0..modulus-1; never less than one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter
//   Modulo-MOD up/down counter with synchronous clear.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : synchronous clear to 0 (wins over up/down)
//     up / down  : step +1 / -1 with wrap; both together hold the value
//     q          : current count, 0..MOD-1
//     carry      : up while q is at MOD-1 (combinational, feeds the next stage)
module mod_counter
    import timekeeper_pkg::*;
#(
    parameter int MOD = 60,
    parameter int W   = cnt_width(MOD)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (up && !down) begin
            r_q <= (r_q == MAXV) ? '0 : r_q + 1'b1;
        end else if (down && !up) begin
            r_q <= (r_q == '0) ? MAXV : r_q - 1'b1;
        end
    end

    assign q     = r_q;
    assign carry = up && (r_q == MAXV);

endmodule

// File: rtl/timekeeper_fsm.sv
// timekeeper_fsm
//   Time-of-day counter (subsec/second/minute/hour) with HOLD, COUNT and SET modes.
//   Ports:
//     clk_10000Hz    : tick clock, TICK_HZ cycles per second
//     rst_n          : asynchronous active-low reset
//     enable         : run request (level)
//     setting_enable : set-mode request (level)
//     set_sel        : field stepped in SET (hour/minute/second/none)
//     inc / dec      : step selected field up / down on rising edge
//     subsec_out, seconds_out, minutes_out, hours_out : registered counter values
//     mode_out       : current FSM state (HOLD/COUNT/SET)
//     sec_tick       : one-cycle strobe with each counted second increment
//     day_wrap       : one-cycle strobe with the rollover to 0:00:00
module timekeeper_fsm
    import timekeeper_pkg::*;
#(
    parameter int TICK_HZ   = 10000,
    parameter int HOURS_MAX = 24,
    parameter int SUBSEC_W  = 14
) (
    input  logic                clk_10000Hz,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                setting_enable,
    input  logic [1:0]          set_sel,
    input  logic                inc,
    input  logic                dec,
    output logic [SUBSEC_W-1:0] subsec_out,
    output logic [5:0]          seconds_out,
    output logic [5:0]          minutes_out,
    output logic [4:0]          hours_out,
    output logic [1:0]          mode_out,
    output logic                sec_tick,
    output logic                day_wrap
);

    state_t r_state;
    logic   r_inc_d;
    logic   r_dec_d;
    logic   r_sec_tick;
    logic   r_day_wrap;

    state_t w_next_state;
    logic   w_count;
    logic   w_in_set;
    logic   w_inc_rise;
    logic   w_dec_rise;
    logic   w_step_up;
    logic   w_step_dn;
    logic   w_sub_carry;
    logic   w_sec_carry;
    logic   w_min_carry;
    logic   w_hr_carry;
    logic   w_sec_wrap;
    logic   w_min_wrap;
    logic   w_day;

    // en=1,se=1 is illegal and simply keeps the current state.
    function automatic state_t fsm_next(input state_t cur, input logic en, input logic se);
        state_t nxt;
        nxt = cur;
        unique case (cur)
            ST_HOLD:  if (en && !se) nxt = ST_COUNT;
                      else if (!en && se) nxt = ST_SET;
            ST_COUNT: if (!en && se) nxt = ST_SET;
                      else if (!en && !se) nxt = ST_HOLD;
            ST_SET:   if (en && !se) nxt = ST_COUNT;
                      else if (!en && !se) nxt = ST_HOLD;
            default:  nxt = ST_HOLD;
        endcase
        return nxt;
    endfunction

    assign w_next_state = fsm_next(r_state, enable, setting_enable);

    // Counting follows the registered state, so the first cycle after leaving
    // COUNT does no count.
    assign w_count = (r_state == ST_COUNT);

    // Stepping and the subsec clear key off the next state: an edge in the cycle
    // that enters SET is honoured, one in the cycle that leaves SET is dropped,
    // and subsec reads 0 in every cycle spent in SET.
    assign w_in_set   = (w_next_state == ST_SET);
    assign w_inc_rise = inc && !r_inc_d;
    assign w_dec_rise = dec && !r_dec_d;
    assign w_step_up  = w_in_set && w_inc_rise && !w_dec_rise;
    assign w_step_dn  = w_in_set && w_dec_rise && !w_inc_rise;

    // Carries only ripple when the stage below was driven by the count chain,
    // so SET steps never spill into neighbouring fields.
    assign w_sec_wrap = w_sec_carry && w_sub_carry;
    assign w_min_wrap = w_min_carry && w_sec_wrap;
    assign w_day      = w_hr_carry && w_min_wrap;

    mod_counter #(.MOD(TICK_HZ), .W(SUBSEC_W)) u_subsec (
        .clk   (clk_10000Hz),
        .rst_n (rst_n),
        .clr   (w_in_set),
        .up    (w_count),
        .down  (1'b0),
        .q     (subsec_out),
        .carry (w_sub_carry)
    );

    mod_counter #(.MOD(SEC_MAX + 1), .W(6)) u_sec (
        .clk   (clk_10000Hz),
        .rst_n (rst_n),
        .clr   (1'b0),
        .up    (w_sub_carry || (w_step_up && set_sel == SEL_SEC)),
        .down  (w_step_dn && set_sel == SEL_SEC),
        .q     (seconds_out),
        .carry (w_sec_carry)
    );

    mod_counter #(.MOD(MIN_MAX + 1), .W(6)) u_min (
        .clk   (clk_10000Hz),
        .rst_n (rst_n),
        .clr   (1'b0),
        .up    (w_sec_wrap || (w_step_up && set_sel == SEL_MIN)),
        .down  (w_step_dn && set_sel == SEL_MIN),
        .q     (minutes_out),
        .carry (w_min_carry)
    );

    mod_counter #(.MOD(HOURS_MAX), .W(5)) u_hour (
        .clk   (clk_10000Hz),
        .rst_n (rst_n),
        .clr   (1'b0),
        .up    (w_min_wrap || (w_step_up && set_sel == SEL_HR)),
        .down  (w_step_dn && set_sel == SEL_HR),
        .q     (hours_out),
        .carry (w_hr_carry)
    );

    // State, edge history and strobes; strobes land on the same edge as the
    // counter update they describe.
    always_ff @(posedge clk_10000Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_HOLD;
            r_inc_d    <= 1'b0;
            r_dec_d    <= 1'b0;
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_inc_d    <= inc;
            r_dec_d    <= dec;
            r_sec_tick <= w_sub_carry;
            r_day_wrap <= w_day;
        end
    end

    assign mode_out = r_state;
    assign sec_tick = r_sec_tick;
    assign day_wrap = r_day_wrap;

endmodule

// File: tb/tb_timekeeper_fsm.sv
module tb_timekeeper_fsm;

    localparam int TICK = 4;
    localparam int SW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          setting_enable;
    logic [1:0]    set_sel;
    logic          inc;
    logic          dec;

    logic [SW-1:0] sub_a, sub_b;
    logic [5:0]    sec_a, sec_b, min_a, min_b;
    logic [4:0]    hr_a, hr_b;
    logic [1:0]    mode_a, mode_b;
    logic          tick_a, tick_b, wrap_a, wrap_b;

    int n_total = 0;
    int n_bad   = 0;
    logic [SW-1:0] exp_q[$];

    always #5 clk = ~clk;

    timekeeper_fsm #(.TICK_HZ(TICK), .HOURS_MAX(24), .SUBSEC_W(SW)) u_dut24 (
        .clk_10000Hz(clk), .rst_n(rst_n), .enable(enable), .setting_enable(setting_enable),
        .set_sel(set_sel), .inc(inc), .dec(dec),
        .subsec_out(sub_a), .seconds_out(sec_a), .minutes_out(min_a), .hours_out(hr_a),
        .mode_out(mode_a), .sec_tick(tick_a), .day_wrap(wrap_a)
    );

    timekeeper_fsm #(.TICK_HZ(TICK), .HOURS_MAX(12), .SUBSEC_W(SW)) u_dut12 (
        .clk_10000Hz(clk), .rst_n(rst_n), .enable(enable), .setting_enable(setting_enable),
        .set_sel(set_sel), .inc(inc), .dec(dec),
        .subsec_out(sub_b), .seconds_out(sec_b), .minutes_out(min_b), .hours_out(hr_b),
        .mode_out(mode_b), .sec_tick(tick_b), .day_wrap(wrap_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        setting_enable = 1'b0;
        set_sel = 2'b11;
        inc = 1'b0;
        dec = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic pulse_inc();
        inc = 1'b1;
        step(1);
        inc = 1'b0;
        step(1);
    endtask

    task automatic pulse_dec();
        dec = 1'b1;
        step(1);
        dec = 1'b0;
        step(1);
    endtask

    task automatic chk_time24(input string tag, input int s, input int m, input int h);
        chk({tag, "_sec"}, int'(sec_a), s);
        chk({tag, "_min"}, int'(min_a), m);
        chk({tag, "_hr"},  int'(hr_a),  h);
    endtask

    initial begin
        // ---- reset state
        do_reset();
        chk("rst_sub", int'(sub_a), 0);
        chk_time24("rst", 0, 0, 0);
        chk("rst_mode", int'(mode_a), 0);
        chk("rst_tick", int'(tick_a), 0);
        chk("rst_wrap", int'(wrap_a), 0);

        // ---- 1: count one second
        enable = 1'b1;
        step(1);
        chk("t1_mode", int'(mode_a), 1);
        chk("t1_sub0", int'(sub_a), 0);
        exp_q.push_back(SW'(1));
        exp_q.push_back(SW'(2));
        exp_q.push_back(SW'(3));
        exp_q.push_back(SW'(0));
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk($sformatf("t1_sub%0d", i + 1), int'(sub_a), int'(exp_q.pop_front()));
            chk($sformatf("t1_tick%0d", i + 1), int'(tick_a), (i == 3) ? 1 : 0);
        end
        chk("t1_sec", int'(sec_a), 1);
        step(1);
        chk("t1_tick_off", int'(tick_a), 0);
        chk("t1_sub_next", int'(sub_a), 1);

        // ---- 2: day rollover, both hour moduli
        do_reset();
        setting_enable = 1'b1;
        step(1);
        chk("t2_mode_set", int'(mode_a), 2);
        set_sel = 2'b00; pulse_dec();
        set_sel = 2'b01; pulse_dec();
        set_sel = 2'b10; pulse_dec();
        set_sel = 2'b11;
        chk_time24("t2_pre", 59, 59, 23);
        chk("t2_pre_hr12", int'(hr_b), 11);
        setting_enable = 1'b0;
        enable = 1'b1;
        step(1);
        chk("t2_entry_sub", int'(sub_a), 0);
        step(3);
        chk("t2_sub3", int'(sub_a), 3);
        chk_time24("t2_hold", 59, 59, 23);
        step(1);
        chk_time24("t2_wrap", 0, 0, 0);
        chk("t2_sub_wrap", int'(sub_a), 0);
        chk("t2_tick", int'(tick_a), 1);
        chk("t2_daywrap", int'(wrap_a), 1);
        chk("t2_hr12", int'(hr_b), 0);
        chk("t2_min12", int'(min_b), 0);
        chk("t2_sec12", int'(sec_b), 0);
        chk("t2_daywrap12", int'(wrap_b), 1);
        step(1);
        chk("t2_daywrap_off", int'(wrap_a), 0);
        chk("t2_tick_off", int'(tick_a), 0);

        // ---- 3: held dec gives one step, no carry
        do_reset();
        setting_enable = 1'b1;
        step(1);
        set_sel = 2'b01;
        dec = 1'b1;
        step(5);
        chk("t3_min", int'(min_a), 59);
        chk("t3_hr", int'(hr_a), 0);
        chk("t3_sec", int'(sec_a), 0);
        chk("t3_sub", int'(sub_a), 0);
        dec = 1'b0;
        step(1);

        // ---- 4: simultaneous edges, hour wrap, set_sel none
        set_sel = 2'b00;
        inc = 1'b1;
        dec = 1'b1;
        step(1);
        chk("t4_both_hr", int'(hr_a), 0);
        chk("t4_both_min", int'(min_a), 59);
        inc = 1'b0;
        dec = 1'b0;
        step(1);
        pulse_dec();
        chk("t4_hr23", int'(hr_a), 23);
        inc = 1'b1;
        step(1);
        chk("t4_hr_wrap", int'(hr_a), 0);
        chk("t4_no_daywrap", int'(wrap_a), 0);
        chk("t4_no_tick", int'(tick_a), 0);
        chk("t4_hr12_wrap", int'(hr_b), 0);
        inc = 1'b0;
        step(1);
        set_sel = 2'b11;
        pulse_inc();
        chk_time24("t4_none", 0, 59, 0);
        set_sel = 2'b10;
        pulse_inc();
        chk_time24("t4_sec_inc", 1, 59, 0);

        // ---- 5: HOLD freeze, illegal request, resume
        do_reset();
        enable = 1'b1;
        step(1);
        step(1);
        chk("t5_sub1", int'(sub_a), 1);
        enable = 1'b0;
        step(1);
        chk("t5_mode_hold", int'(mode_a), 0);
        chk("t5_sub_exit", int'(sub_a), 2);
        step(10);
        chk("t5_frozen_sub", int'(sub_a), 2);
        chk("t5_frozen_sec", int'(sec_a), 0);
        chk("t5_frozen_tick", int'(tick_a), 0);
        enable = 1'b1;
        setting_enable = 1'b1;
        step(2);
        chk("t5_illegal_mode", int'(mode_a), 0);
        chk("t5_illegal_sub", int'(sub_a), 2);
        setting_enable = 1'b0;
        step(1);
        chk("t5_resume_mode", int'(mode_a), 1);
        chk("t5_resume_sub", int'(sub_a), 2);
        step(1);
        chk("t5_count_sub", int'(sub_a), 3);

        // ---- 6: async reset mid-SET at 12:34:56
        do_reset();
        setting_enable = 1'b1;
        step(1);
        set_sel = 2'b00;
        for (int i = 0; i < 12; i++) pulse_inc();
        set_sel = 2'b01;
        for (int i = 0; i < 34; i++) pulse_inc();
        set_sel = 2'b10;
        for (int i = 0; i < 4; i++) pulse_dec();
        chk_time24("t6_pre", 56, 34, 12);
        chk("t6_pre_mode", int'(mode_a), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_time24("t6_async", 0, 0, 0);
        chk("t6_async_sub", int'(sub_a), 0);
        chk("t6_async_mode", int'(mode_a), 0);
        do_reset();
        chk("t6_after_mode", int'(mode_a), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
